// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue/writeback stage: instruction field
// positions, the shift-group func mask, FSM encoding and small decode helpers.
package alu_issue_stage_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    // R-type shifts are the func codes whose upper three bits are all zero.
    localparam logic [5:0] SHIFT_FUNC_MASK = 6'b111000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [5:0] opcode, input logic [5:0] func);
        return (opcode == 6'd0) && ((func & SHIFT_FUNC_MASK) == 6'd0);
    endfunction

    function automatic logic [4:0] dest_idx(input logic [5:0] opcode, input logic [4:0] rt,
                                            input logic [4:0] rd);
        return (opcode == 6'd0) ? rd : rt;
    endfunction

endpackage

// File: rtl/alu_issue_stage_gpr_file.sv
// 32x32 general-purpose register file: one synchronous write port, two
// combinational read ports, r0 hardwired to zero.
module gpr_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every entry is cleared on reset, so this array maps to
            // flops rather than a RAM macro; the architecture requires it.
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of the combinational alu: IDLE -> EXEC -> WB.
// Optional macro ALU_ISSUE_BYPASS_EN: accept in WB and forward the WB result.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        ld_we,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_gr1,
    input  logic [31:0] alu_c,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] gr1_q, gr1_d;
    logic [4:0]  dest_q, dest_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [5:0]  in_opcode, in_func;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [4:0]  op_idx;
    logic [31:0] op_rdata, op_value;
    logic        accept, bypass_hit;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    assign in_opcode = in_instr[OPCODE_MSB:OPCODE_LSB];
    assign in_rs     = in_instr[RS_MSB:RS_LSB];
    assign in_rt     = in_instr[RT_MSB:RT_LSB];
    assign in_rd     = in_instr[RD_MSB:RD_LSB];
    assign in_func   = in_instr[FUNC_MSB:FUNC_LSB];

    assign op_idx = is_shift(in_opcode, in_func) ? in_rt : in_rs;
    assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    // The WB write lands on the same edge as this read, so take it from the result register.
    assign bypass_hit = (state_q == ST_WB) && (wb_addr_q != 5'd0) && (op_idx == wb_addr_q);
`else
    assign bypass_hit = 1'b0;
`endif
    assign op_value = bypass_hit ? wb_data_q : op_rdata;

    gpr_file u_gpr (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (gpr_we),
        .waddr   (gpr_waddr),
        .wdata   (gpr_wdata),
        .raddr_a (op_idx),
        .rdata_a (op_rdata),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (rst_n && !ld_we) begin
`ifdef ALU_ISSUE_BYPASS_EN
            in_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
`else
            in_ready = (state_q == ST_IDLE);
`endif
        end
        wb_valid = (state_q == ST_WB);
    end

    always_comb begin
        instr_d   = instr_q;
        gr1_d     = gr1_q;
        dest_d    = dest_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (accept) begin
            instr_d = in_instr;
            gr1_d   = op_value;
            dest_d  = dest_idx(in_opcode, in_rt, in_rd);
        end
        if (state_q == ST_EXEC) begin
            wb_addr_d = dest_q;
            wb_data_d = alu_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            gr1_q     <= '0;
            dest_q    <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            instr_q   <= instr_d;
            gr1_q     <= gr1_d;
            dest_q    <= dest_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Preload owns the write port in IDLE, writeback owns it in WB.
    always_comb begin
        gpr_we    = 1'b0;
        gpr_waddr = ld_addr;
        gpr_wdata = ld_data;
        if (state_q == ST_WB) begin
            gpr_we    = 1'b1;
            gpr_waddr = wb_addr_q;
            gpr_wdata = wb_data_q;
        end else if (state_q == ST_IDLE) begin
            gpr_we = ld_we;
        end
    end

    assign alu_instr = instr_q;
    assign alu_gr1   = gr1_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

endmodule
